bios_loader: RTL and testbench

- Boot-time copy sequencer. Streams the BIOS image (NEXTOR 128KB followed by FM-BIOS 16KB) from SPI flash at 10_0000 into SD-RAM at 70_0000.
- Sits between the flash reader and one SD-RAM arbiter port.
- Holds BUSY high until the copy finishes, so slot logic keeps the MSX bus in WAIT and BIOS reads are not served early.
- The flash read of the next word overlaps the SD-RAM write of the current word.

---
 rtl/bios_loader.sv | 202 ++++++++++++++++++++
 tb/tb_bios_loader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_loader.sv
// Boot-time copy sequencer: streams the BIOS image from SPI flash into SD-RAM.
// A byte-wide flash reader fills a 16-bit hold register, and a word-wide
// SD-RAM writer drains it. The next flash fetch overlaps the current RAM write.
// BUSY stays high until the last word is accepted or an ACK times out.
module bios_loader #(
    parameter logic [23:0] SRC_ADDR = 24'h10_0000,
    parameter logic [23:0] DST_ADDR = 24'h70_0000,
    parameter logic [23:0] SIZE     = 24'h02_4000,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [23:0] FLASH_ADDR,
    output logic        FLASH_REQ,
    input  logic        FLASH_ACK,
    input  logic [7:0]  FLASH_DATA,
    output logic [23:0] RAM_ADDR,
    output logic        RAM_WE,
    output logic [15:0] RAM_DIN,
    input  logic        RAM_ACK
);

    localparam int unsigned    TW     = $clog2(TIMEOUT + 1);
    localparam logic [23:0]    WORDS  = SIZE >> 1;
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {F_IDLE, F_LO, F_HI, F_FULL} f_state_t;
    typedef enum logic       {R_IDLE, R_WRITE}            r_state_t;

    f_state_t      f_state, f_state_n;
    r_state_t      r_state, r_state_n;
    logic [15:0]   hold, hold_n;
    logic [23:0]   f_count, f_count_n;
    logic [23:0]   w_count, w_count_n;
    logic [TW-1:0] f_timer, f_timer_n;
    logic [TW-1:0] r_timer, r_timer_n;
    logic          boot, boot_n;
    logic          busy_n, done_n, error_n, flash_req_n, ram_we_n;
    logic [23:0]   flash_addr_n, ram_addr_n;
    logic [15:0]   ram_din_n;

    // A run starts either once after reset or on an idle START pulse.
    // ACKs only count while a copy is live; late ACKs after a timeout are dropped.
    logic go, f_ack, r_ack, last_word, ram_free, f_expire, r_expire;
    assign go        = boot | (START & ~BUSY);
    assign f_ack     = BUSY & FLASH_REQ & FLASH_ACK;
    assign r_ack     = BUSY & RAM_WE & RAM_ACK;
    assign last_word = (w_count == WORDS - 24'd1);
    assign ram_free  = (r_state == R_IDLE) | (r_ack & ~last_word);
    assign f_expire  = FLASH_REQ & ~FLASH_ACK & (f_timer == T_LAST);
    assign r_expire  = RAM_WE & ~RAM_ACK & (r_timer == T_LAST);

    // Next-state and next-output logic for both sides of the copy.
    always_comb begin
        // NOTE: every target gets its hold value first so no path can infer a latch.
        f_state_n    = f_state;
        r_state_n    = r_state;
        hold_n       = hold;
        f_count_n    = f_count;
        w_count_n    = w_count;
        f_timer_n    = f_timer;
        r_timer_n    = r_timer;
        boot_n       = boot;
        busy_n       = BUSY;
        done_n       = DONE;
        error_n      = ERROR;
        flash_req_n  = FLASH_REQ;
        ram_we_n     = RAM_WE;
        flash_addr_n = FLASH_ADDR;
        ram_addr_n   = RAM_ADDR;
        ram_din_n    = RAM_DIN;

        if (go) begin
            boot_n       = 1'b0;
            busy_n       = 1'b1;
            done_n       = 1'b0;
            error_n      = 1'b0;
            flash_addr_n = SRC_ADDR;
            ram_addr_n   = DST_ADDR;
            f_count_n    = '0;
            w_count_n    = '0;
            f_state_n    = F_LO;
            flash_req_n  = 1'b1;
            r_state_n    = R_IDLE;
            ram_we_n     = 1'b0;
            f_timer_n    = '0;
            r_timer_n    = '0;
        end else if (!BUSY) begin
            // Idle, or the cycle right after a timeout: park both sides.
            f_state_n   = F_IDLE;
            r_state_n   = R_IDLE;
            flash_req_n = 1'b0;
            ram_we_n    = 1'b0;
            f_timer_n   = '0;
            r_timer_n   = '0;
        end else begin
            f_timer_n = (FLASH_REQ & ~FLASH_ACK) ? f_timer + 1'b1 : '0;
            r_timer_n = (RAM_WE & ~RAM_ACK) ? r_timer + 1'b1 : '0;

            // RAM side retires the current word; the flash side may refill below.
            if (r_state == R_WRITE && r_ack) begin
                ram_addr_n = RAM_ADDR + 24'd2;
                w_count_n  = w_count + 24'd1;
                ram_we_n   = 1'b0;
                r_state_n  = R_IDLE;
            end

            case (f_state)
                F_LO: begin
                    if (f_ack) begin
                        hold_n[7:0]  = FLASH_DATA;
                        flash_addr_n = FLASH_ADDR + 24'd1;
                        f_count_n    = f_count + 24'd1;
                        f_state_n    = F_HI;
                    end
                end
                F_HI: begin
                    if (f_ack) begin
                        hold_n[15:8] = FLASH_DATA;
                        flash_addr_n = FLASH_ADDR + 24'd1;
                        f_count_n    = f_count + 24'd1;
                        f_state_n    = F_FULL;
                        flash_req_n  = 1'b0;
                    end
                end
                F_FULL: begin
                    // Hand the word over without a bubble, even as RAM frees up.
                    if (ram_free) begin
                        ram_din_n = hold;
                        ram_we_n  = 1'b1;
                        r_state_n = R_WRITE;
                        if (f_count == SIZE) begin
                            f_state_n = F_IDLE;
                        end else begin
                            f_state_n   = F_LO;
                            flash_req_n = 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (r_ack && last_word) begin
                busy_n      = 1'b0;
                done_n      = 1'b1;
                ram_we_n    = 1'b0;
                r_state_n   = R_IDLE;
                f_state_n   = F_IDLE;
                flash_req_n = 1'b0;
            end else if (f_expire || r_expire) begin
                error_n = 1'b1;
                busy_n  = 1'b0;
            end
        end
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values and ordering does not matter.
            f_state    <= F_IDLE;
            r_state    <= R_IDLE;
            hold       <= '0;
            f_count    <= '0;
            w_count    <= '0;
            f_timer    <= '0;
            r_timer    <= '0;
            boot       <= 1'b1;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERROR      <= 1'b0;
            FLASH_REQ  <= 1'b0;
            RAM_WE     <= 1'b0;
            FLASH_ADDR <= SRC_ADDR;
            RAM_ADDR   <= DST_ADDR;
            RAM_DIN    <= '0;
        end else begin
            f_state    <= f_state_n;
            r_state    <= r_state_n;
            hold       <= hold_n;
            f_count    <= f_count_n;
            w_count    <= w_count_n;
            f_timer    <= f_timer_n;
            r_timer    <= r_timer_n;
            boot       <= boot_n;
            BUSY       <= busy_n;
            DONE       <= done_n;
            ERROR      <= error_n;
            FLASH_REQ  <= flash_req_n;
            RAM_WE     <= ram_we_n;
            FLASH_ADDR <= flash_addr_n;
            RAM_ADDR   <= ram_addr_n;
            RAM_DIN    <= ram_din_n;
        end
    end

endmodule

// File: tb/tb_bios_loader.sv
// Self-checking bench for bios_loader: an 8-byte image, TIMEOUT=15, and
// flash/RAM responders with programmable ACK latency.
module tb_bios_loader;

    localparam logic [23:0] SRC = 24'h10_0000;
    localparam logic [23:0] DST = 24'h70_0000;
    localparam logic [23:0] SZ  = 24'd8;
    localparam int          TO  = 15;

    logic        CLK = 1'b0;
    logic        RESET, START;
    logic        BUSY, DONE, ERROR;
    logic [23:0] FLASH_ADDR;
    logic        FLASH_REQ, FLASH_ACK;
    logic [7:0]  FLASH_DATA;
    logic [23:0] RAM_ADDR;
    logic        RAM_WE, RAM_ACK;
    logic [15:0] RAM_DIN;

    always #5 CLK = ~CLK;

    bios_loader #(.SRC_ADDR(SRC), .DST_ADDR(DST), .SIZE(SZ), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
        .FLASH_ADDR(FLASH_ADDR), .FLASH_REQ(FLASH_REQ),
        .FLASH_ACK(FLASH_ACK), .FLASH_DATA(FLASH_DATA),
        .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_DIN(RAM_DIN), .RAM_ACK(RAM_ACK)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Responder knobs and the RAM write log.
    int          flash_delay = 2;
    int          ram_delay   = 2;
    bit          flash_en    = 1'b1;
    bit          flash_force = 1'b0;
    logic [7:0]  img_base    = 8'h11;
    logic [23:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          last_ram_ack = 0;

    // Flash image: byte at offset i is img_base + 0x11*i.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        logic [23:0] off;
        logic [7:0]  o8, r;
        off = a - SRC;
        o8  = off[7:0];
        r   = img_base + o8 * 8'h11;
        return r;
    endfunction

    // Flash responder: ACK flash_delay cycles after the request is seen.
    initial begin
        int f_wait;
        f_wait = 0;
        FLASH_ACK = 1'b0;
        FLASH_DATA = 8'h00;
        forever begin
            @(posedge CLK); #1;
            FLASH_ACK = 1'b0;
            if (flash_force) begin
                FLASH_ACK  = 1'b1;
                FLASH_DATA = 8'hEE;
            end else if (flash_en && FLASH_REQ) begin
                if (f_wait >= flash_delay) begin
                    FLASH_ACK  = 1'b1;
                    FLASH_DATA = flash_byte(FLASH_ADDR);
                    f_wait     = 0;
                end else begin
                    f_wait++;
                end
            end else begin
                f_wait = 0;
            end
        end
    end

    // RAM responder: ACK ram_delay cycles after RAM_WE is seen, log the write.
    initial begin
        int r_wait;
        r_wait = 0;
        RAM_ACK = 1'b0;
        forever begin
            @(posedge CLK); #1;
            RAM_ACK = 1'b0;
            if (RAM_WE) begin
                if (r_wait >= ram_delay) begin
                    RAM_ACK = 1'b1;
                    wr_addr.push_back(RAM_ADDR);
                    wr_data.push_back(RAM_DIN);
                    last_ram_ack = cyc;
                    r_wait = 0;
                end else begin
                    r_wait++;
                end
            end else begin
                r_wait = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    // Wait for the run to end; optionally poke START mid-run; check completion.
    task automatic wait_end(input string tag, input int budget, input int poke_at);
        int n;
        n = 0;
        while (!(DONE || ERROR) && n < budget) begin
            START = (poke_at > 0 && n == poke_at);
            @(negedge CLK);
            n++;
        end
        START = 1'b0;
        if (!(DONE || ERROR)) begin
            checks++;
            failures++;
            $display("FAIL %s_end: no DONE/ERROR within %0d cycles", tag, budget);
        end else begin
            check({tag, "_done"}, 32'(DONE), 1);
            check({tag, "_error"}, 32'(ERROR), 0);
            check({tag, "_busy_low"}, 32'(BUSY), 0);
            check({tag, "_done_latency"}, cyc - last_ram_ack, 1);
            check({tag, "_req_low"}, 32'({FLASH_REQ, RAM_WE}), 0);
        end
    endtask

    task automatic check_log(input string tag, input logic [3:0][15:0] exp);
        check({tag, "_words"}, wr_addr.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < wr_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, k), 32'(wr_addr[k]), 32'(DST + 24'(2 * k)));
                check($sformatf("%s_data%0d", tag, k), 32'(wr_data[k]), 32'(exp[k]));
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(BUSY), 0);
        check({tag, "_done"}, 32'(DONE), 0);
        check({tag, "_error"}, 32'(ERROR), 0);
        check({tag, "_flash_req"}, 32'(FLASH_REQ), 0);
        check({tag, "_ram_we"}, 32'(RAM_WE), 0);
        check({tag, "_flash_addr"}, 32'(FLASH_ADDR), 32'(SRC));
        check({tag, "_ram_addr"}, 32'(RAM_ADDR), 32'(DST));
        check({tag, "_ram_din"}, 32'(RAM_DIN), 0);
    endtask

    typedef struct {
        int               fd;
        int               rd;
        logic [7:0]       base;
        int               poke;
        logic [3:0][15:0] exp;
    } vec_t;

    localparam logic [3:0][15:0] IMG11 = {16'h8877, 16'h6655, 16'h4433, 16'h2211};

    initial begin
        vec_t vecs[4];
        int   n, facks, err_cyc, req_cyc;
        bit   overlap_seen, both_seen;

        vecs[0] = '{2, 2, 8'h11, 0, IMG11};
        vecs[1] = '{0, 0, 8'h05, 0, {16'h7C6B, 16'h5A49, 16'h3827, 16'h1605}};
        vecs[2] = '{1, 5, 8'hF0, 8, {16'h6756, 16'h4534, 16'h2312, 16'h01F0}};
        vecs[3] = '{3, 0, 8'h11, 0, IMG11};

        // Reset state and auto-start.
        RESET = 1'b1;
        START = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_values("reset");
        RESET = 1'b0;
        @(negedge CLK);
        check("auto_busy", 32'(BUSY), 1);
        check("auto_flash_req", 32'(FLASH_REQ), 1);
        check("auto_flash_addr", 32'(FLASH_ADDR), 32'(SRC));
        wait_end("auto", 300, 0);
        check_log("auto", IMG11);

        // Table of re-runs via START with various latencies and images.
        for (int v = 0; v < 4; v++) begin
            flash_delay = vecs[v].fd;
            ram_delay   = vecs[v].rd;
            img_base    = vecs[v].base;
            clear_log();
            pulse_start();
            check($sformatf("v%0d_start_busy", v), 32'(BUSY), 1);
            check($sformatf("v%0d_start_done_clr", v), 32'(DONE), 0);
            check($sformatf("v%0d_start_faddr", v), 32'(FLASH_ADDR), 32'(SRC));
            check($sformatf("v%0d_start_raddr", v), 32'(RAM_ADDR), 32'(DST));
            wait_end($sformatf("v%0d", v), 400, vecs[v].poke);
            check_log($sformatf("v%0d", v), vecs[v].exp);
        end

        // Overlap: slow RAM ACK, flash prefetches exactly one word ahead.
        flash_delay = 1;
        ram_delay   = 12;
        img_base    = 8'h11;
        clear_log();
        pulse_start();
        overlap_seen = 1'b0;
        facks = 0;
        n = 0;
        while (wr_addr.size() < 1 && n < 200) begin
            if (FLASH_REQ && RAM_WE) overlap_seen = 1'b1;
            if (FLASH_REQ && FLASH_ACK) facks++;
            @(negedge CLK);
            n++;
        end
        check("ovl_first_ack_seen", wr_addr.size(), 1);
        check("ovl_req_during_we", 32'(overlap_seen), 1);
        check("ovl_bytes_before_ack", facks, 4);
        check("ovl_flash_parked", 32'(FLASH_REQ), 0);
        wait_end("ovl", 400, 0);
        check_log("ovl", IMG11);

        // Same-cycle FLASH_ACK (byte 3) and RAM_ACK (word 0).
        flash_delay = 2;
        ram_delay   = 5;
        clear_log();
        pulse_start();
        both_seen = 1'b0;
        n = 0;
        while (!both_seen && n < 60) begin
            if (FLASH_ACK && RAM_ACK) both_seen = 1'b1;
            else begin
                @(negedge CLK);
                n++;
            end
        end
        check("same_both_acks", 32'(both_seen), 1);
        check("same_words_so_far", wr_addr.size(), 1);
        @(negedge CLK);
        n = 0;
        while (!RAM_WE && n < 3) begin
            @(negedge CLK);
            n++;
        end
        check("same_next_we", 32'(RAM_WE), 1);
        check("same_next_addr", 32'(RAM_ADDR), 32'(DST + 24'd2));
        check("same_next_data", 32'(RAM_DIN), 32'h4433);
        wait_end("same", 300, 0);
        check_log("same", IMG11);

        // Timeout: flash never answers.
        flash_en = 1'b0;
        clear_log();
        pulse_start();
        req_cyc = cyc;
        check("to_req_high", 32'(FLASH_REQ), 1);
        n = 0;
        while (!ERROR && n < 40) begin
            @(negedge CLK);
            n++;
        end
        err_cyc = cyc;
        check("to_error", 32'(ERROR), 1);
        check("to_latency", err_cyc - req_cyc, TO);
        check("to_busy", 32'(BUSY), 0);
        check("to_done", 32'(DONE), 0);
        @(negedge CLK);
        check("to_req_drop", 32'(FLASH_REQ), 0);
        flash_force = 1'b1;
        repeat (3) @(negedge CLK);
        flash_force = 1'b0;
        @(negedge CLK);
        check("to_late_ack_error", 32'(ERROR), 1);
        check("to_late_ack_done", 32'(DONE), 0);
        check("to_late_ack_busy", 32'(BUSY), 0);
        check("to_late_ack_faddr", 32'(FLASH_ADDR), 32'(SRC));
        check("to_late_ack_writes", wr_addr.size(), 0);
        flash_en = 1'b1;

        // RESET after three words; copy restarts from the first byte.
        flash_delay = 1;
        ram_delay   = 1;
        clear_log();
        pulse_start();
        check("rst_error_clr", 32'(ERROR), 0);
        n = 0;
        while (wr_addr.size() < 3 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("rst_three_words", wr_addr.size(), 3);
        RESET = 1'b1;
        @(negedge CLK);
        check_reset_values("midrst");
        @(negedge CLK);
        clear_log();
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_restart_busy", 32'(BUSY), 1);
        check("rst_restart_faddr", 32'(FLASH_ADDR), 32'(SRC));
        wait_end("rst", 300, 0);
        check_log("rst", IMG11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
